icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 113 +++++++++++
 tb/tb_icache.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, blocking instruction cache. Hits return in the same cycle;
// misses refill the whole line one word at a time from the memory controller.
module icache #(
  parameter int unsigned LINE_NUM   = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        enable,
  input  logic [31:0] pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW = $clog2(LINE_NUM);
  localparam int unsigned TagW = 30 - OffW - IdxW;

  typedef enum logic {StIdle, StRefill} state_e;

  state_e                state_q, state_d;
  logic [OffW-1:0]       cnt_q, cnt_d;
  logic [TagW-1:0]       base_tag_q, base_tag_d;
  logic [IdxW-1:0]       base_idx_q, base_idx_d;
  logic [LINE_NUM-1:0]   valid_q, valid_d;
  logic [TagW-1:0]       tag_q [LINE_NUM];
  logic [TagW-1:0]       tag_d [LINE_NUM];
  logic [31:0]           data_q [LINE_NUM*LINE_WORDS];
  logic [31:0]           data_d [LINE_NUM*LINE_WORDS];

  logic [OffW-1:0] pc_off;
  logic [IdxW-1:0] pc_idx;
  logic [TagW-1:0] pc_tag;
  logic            hit;
  logic            unused_pc_lsb;

  assign pc_off        = pc[OffW+1:2];
  assign pc_idx        = pc[IdxW+OffW+1:OffW+2];
  assign pc_tag        = pc[31:IdxW+OffW+2];
  assign unused_pc_lsb = ^pc[1:0];

  assign hit        = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign inst_valid = (state_q == StIdle) && rdy && enable && hit;
  assign inst       = data_q[{pc_idx, pc_off}];
  assign mc_req     = (state_q == StRefill) && rdy;
  // The latched line base plus word counter is the request address; all zero after reset.
  assign mc_addr    = {base_tag_q, base_idx_q, cnt_q, 2'b00};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_tag_d = base_tag_q;
    base_idx_d = base_idx_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    if (rdy) begin
      case (state_q)
        StIdle: begin
          if (enable && !hit) begin
            base_tag_d      = pc_tag;
            base_idx_d      = pc_idx;
            valid_d[pc_idx] = 1'b0;
            tag_d[pc_idx]   = pc_tag;
            cnt_d           = '0;
            state_d         = StRefill;
          end
        end
        StRefill: begin
          if (mc_done) begin
            data_d[{base_idx_q, cnt_q}] = mc_data;
            cnt_d = cnt_q + OffW'(1);
            if (cnt_q == OffW'(LINE_WORDS - 1)) begin
              valid_d[base_idx_q] = 1'b1;
              state_d             = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      base_tag_q <= '0;
      base_idx_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_tag_q <= base_tag_d;
      base_idx_q <= base_idx_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data storage need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: acts as the memory controller and checks every
// cycle against a line-level model of which lines are resident.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, enable, mc_done;
  logic [31:0] pc, mc_data;
  logic        inst_valid, mc_req;
  logic [31:0] inst, mc_addr;

  int n_cmp = 0;
  int n_err = 0;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .enable    (enable),
    .pc        (pc),
    .inst_valid(inst_valid),
    .inst      (inst),
    .mc_req    (mc_req),
    .mc_addr   (mc_addr),
    .mc_done   (mc_done),
    .mc_data   (mc_data)
  );

  always #5 clk = ~clk;

  // Model: resident line base per index, plus the addresses still owed by a refill.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] exp_q   [$];
  int          m_fill_idx;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input logic r, input logic rd, input logic en,
                      input logic [31:0] p, input logic dn);
    bit          refill, m_hit;
    int          idx;
    logic [21:0] tg;
    @(negedge clk);
    rst     = r;
    rdy     = rd;
    enable  = en;
    pc      = p;
    refill  = exp_q.size() != 0;
    mc_done = dn;
    mc_data = refill ? mem_word(exp_q[0]) : $urandom;
    idx     = int'(p[9:4]);
    tg      = p[31:10];
    m_hit   = m_valid[idx] && (m_tag[idx] == tg);
    #1;
    if (!r) begin
      check("mc_req", 32'(mc_req), 32'(rd && refill));
      check("inst_valid", 32'(inst_valid), 32'(!refill && rd && en && m_hit));
      if (rd && refill) check("mc_addr", mc_addr, exp_q[0]);
      if (!refill && rd && en && m_hit) check("inst", inst, mem_word({p[31:2], 2'b00}));
    end
    if (r) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      exp_q.delete();
    end else if (rd) begin
      if (!refill && en && !m_hit) begin
        m_valid[idx] = 1'b0;
        m_tag[idx]   = tg;
        m_fill_idx   = idx;
        for (int w = 0; w < 4; w++) exp_q.push_back({p[31:4], 4'h0} + 32'(4 * w));
      end else if (refill && dn) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_valid[m_fill_idx] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] rp;
    rst = 1'b1; rdy = 1'b1; enable = 1'b0; pc = '0; mc_done = 1'b0; mc_data = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    step(1, 1, 0, 32'h0, 0);
    step(1, 0, 1, 32'h0, 1);
    step(0, 1, 0, 32'h0, 0);
    check("rst_mc_addr", mc_addr, 32'h0);

    // Cold miss, fill with a gap, then hits.
    step(0, 1, 1, 32'h1000, 0);
    step(0, 1, 1, 32'h1000, 1);
    step(0, 1, 1, 32'h1000, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 32'h1000, 1);
    step(0, 1, 1, 32'h1000, 0);
    step(0, 1, 1, 32'h1008, 1);
    step(0, 1, 1, 32'h100C, 0);
    // Conflict at index 0, then the old line misses again.
    step(0, 1, 1, 32'h1400, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 32'h1400, 1);
    step(0, 1, 1, 32'h1404, 0);
    step(0, 1, 1, 32'h1000, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 32'h1000, 1);
    // pc changes mid-refill; rdy dropped with ignored done pulses.
    step(0, 1, 1, 32'h2000, 0);
    step(0, 1, 1, 32'h2000, 1);
    step(0, 1, 1, 32'h2000, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 32'h3000, 1);
    for (int k = 0; k < 2; k++) step(0, 1, 1, 32'h3000, 1);
    step(0, 1, 1, 32'h3000, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 32'h3000, 1);
    step(0, 1, 1, 32'h2004, 0);
    // Reset mid-refill; the abandoned line must miss afterwards.
    step(0, 1, 1, 32'h4010, 0);
    step(0, 1, 1, 32'h4010, 1);
    step(0, 1, 1, 32'h4010, 1);
    step(1, 1, 1, 32'h4010, 0);
    step(0, 1, 0, 32'h4010, 1);
    step(0, 1, 1, 32'h4010, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 32'h4010, 1);
    step(0, 1, 1, 32'h4014, 0);

    // Random traffic over a few tags/indices to mix hits, conflicts and stalls.
    for (int n = 0; n < 4000; n++) begin
      rp = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0, rp, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
